// File: rtl/x_window_row_ctrl.sv
// Row sequencer for a 5-tap horizontal filter: pads rows, drives filter beats, keeps the WIDTH*HEIGHT valid results.
// Filter result lands one cycle after its beat; beats stall while the 2-entry output FIFO could overflow.
module x_window_row_ctrl #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int PIPE_DEPTH = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_sof,
    input  logic       in_eol,
    output logic       in_ready,
    output logic [7:0] filt_din,
    output logic       filt_valid,
    input  logic [7:0] filt_dout,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_sof,
    output logic       out_eol,
    input  logic       out_ready,
    output logic       busy,
    output logic       err
);
    localparam int TOTAL = HEIGHT * (WIDTH + 4) + PIPE_DEPTH;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int KW    = $clog2(WIDTH * HEIGHT + 1);
    localparam int XW    = $clog2(WIDTH + 5);
    localparam int BW    = $clog2(WIDTH + PIPE_DEPTH + 1);
    localparam int RW    = $clog2(HEIGHT + 1);

    typedef enum logic [2:0] {IDLE, PAD_L, ROW, PAD_R, FLUSH} state_t;

    state_t          state;
    logic [BW-1:0]   cnt;
    logic [RW-1:0]   row_cnt;
    logic [7:0]      pix;
    logic            fill;
    logic            cap_vld;
    logic [CW-1:0]   cap_idx;
    logic [XW-1:0]   col;
    logic [KW-1:0]   kept;
    logic [9:0]      mem [2];
    logic            wr_ptr, rd_ptr;
    logic [1:0]      fifo_cnt;
    logic            beat, accept, space, pop, keep;
    logic [7:0]      din;
    logic [2:0]      occ;
    logic [9:0]      head;

    assign out_valid = (fifo_cnt != 2'd0);
    assign pop       = out_valid && out_ready;
    // A beat issued now lands in the FIFO two edges later, so count last cycle's beat as occupied.
    assign occ       = {1'b0, fifo_cnt} + {2'b0, cap_vld} - {2'b0, pop};
    assign space     = (occ < 3'd2);

    always_comb begin
        beat   = 1'b0;
        accept = 1'b0;
        din    = pix;
        case (state)
            IDLE:  accept = in_valid && !in_sof;
            PAD_L: begin
                beat = in_valid && space;
                din  = in_data;
            end
            ROW: begin
                if (fill) begin
                    beat = space;
                end else begin
                    beat   = in_valid && space;
                    accept = beat;
                    din    = in_data;
                end
            end
            PAD_R, FLUSH: beat = space;
            default: beat = 1'b0;
        endcase
    end

    assign filt_valid = beat;
    assign filt_din   = beat ? din : 8'd0;
    assign in_ready   = accept;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            row_cnt <= '0;
            pix     <= '0;
            fill    <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (in_sof) begin
                            state   <= PAD_L;
                            cnt     <= '0;
                            row_cnt <= '0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                PAD_L: begin
                    if (beat) begin
                        pix <= in_data;
                        if (cnt == BW'(1)) begin
                            state <= ROW;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + BW'(1);
                        end
                    end
                end
                ROW: begin
                    if (beat) begin
                        if (!fill) begin
                            pix <= in_data;
                            if (in_sof && !(row_cnt == '0 && cnt == '0))
                                err <= 1'b1;
                        end
                        if (cnt == BW'(WIDTH - 1)) begin
                            state <= PAD_R;
                            cnt   <= '0;
                            fill  <= 1'b0;
                            if (!fill && !in_eol)
                                err <= 1'b1;
                        end else begin
                            cnt <= cnt + BW'(1);
                            // Short row: pad the remaining slots with the last pixel seen.
                            if (!fill && in_eol) begin
                                err  <= 1'b1;
                                fill <= 1'b1;
                            end
                        end
                    end
                end
                PAD_R: begin
                    if (beat) begin
                        if (cnt == BW'(1)) begin
                            cnt <= '0;
                            if (row_cnt < RW'(HEIGHT - 1)) begin
                                row_cnt <= row_cnt + RW'(1);
                                state   <= PAD_L;
                            end else begin
                                state <= FLUSH;
                            end
                        end else begin
                            cnt <= cnt + BW'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (beat) begin
                        if (cnt == BW'(PIPE_DEPTH - 1)) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + BW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign keep = cap_vld && (cap_idx >= CW'(PIPE_DEPTH)) && (col < XW'(WIDTH))
                  && (kept < KW'(WIDTH * HEIGHT));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cap_vld  <= 1'b0;
            cap_idx  <= '0;
            col      <= '0;
            kept     <= '0;
            mem[0]   <= '0;
            mem[1]   <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= '0;
        end else begin
            cap_vld <= beat;
            if (cap_vld) begin
                // Beat count per frame is fixed, so the last result realigns the counters.
                if (cap_idx == CW'(TOTAL - 1)) begin
                    cap_idx <= '0;
                    col     <= '0;
                    kept    <= '0;
                end else begin
                    cap_idx <= cap_idx + CW'(1);
                    if (cap_idx >= CW'(PIPE_DEPTH))
                        col <= (col == XW'(WIDTH + 3)) ? '0 : col + XW'(1);
                    if (keep)
                        kept <= kept + KW'(1);
                end
            end
            if (keep) begin
                mem[wr_ptr] <= {col == XW'(WIDTH - 1), kept == '0, filt_dout};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + {1'b0, keep} - {1'b0, pop};
        end
    end

    assign head     = mem[rd_ptr];
    assign out_data = out_valid ? head[7:0] : 8'd0;
    assign out_sof  = out_valid && head[8];
    assign out_eol  = out_valid && head[9];
    assign busy     = (state != IDLE) || out_valid;

endmodule
